mul_share_arbiter: RTL

Round-robin arbiter and issue sequencer that shares one pipelined 32x32 multiplier between `NUM_REQ` requesters. Each requester presents an operand pair over a valid/ready handshake. The block grants one request per cycle and issues it into the multiplier. A tag pipeline tracks each operation, and every product is returned on a common response bus carrying the originating requester ID. It sits between the MAC front-end lanes and the shared multiplication datapath.

---
 rtl/mul_arb_pkg.sv | 34 +++
 rtl/mul_pipe.sv | 26 ++
 rtl/mul_share_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared constants, tag type and round-robin pick function
package mul_arb_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 2;
  localparam int MAX_REQ     = 8;
  localparam int MAX_ID_W    = 3;

  // One tag-pipeline entry; also reused as the {found, id} result of the arbiter search
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  // First valid requester searching from last+1 (mod num_req); valid=0 when none requests
  function automatic tag_t rr_pick(input logic [MAX_ID_W-1:0] last,
                                   input logic [MAX_REQ-1:0]  valid,
                                   input int                  num_req);
    tag_t r;
    int   idx;
    r = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = (int'(last) + k) % num_req;
        if (valid[idx[MAX_ID_W-1:0]]) begin
          r.valid = 1'b1;
          r.id    = idx[MAX_ID_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - MUL_LAT-stage pipelined unsigned multiplier, truncated product
module mul_pipe
  import mul_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  logic [WIDTH-1:0] stage_q [MUL_LAT];

  // Multiply into the first stage, then shift the product down the pipe
  always_ff @(posedge clk) begin
    stage_q[0] <= a_i * b_i;
    for (int s = 1; s < MUL_LAT; s++) begin
      stage_q[s] <= stage_q[s-1];
    end
  end

  assign p_o = stage_q[MUL_LAT-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin issue of NUM_REQ requesters into one shared multiplier (option: MUL_ARB_OUT_REG_EN)
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     busy,
  output logic [15:0]              issue_cnt
);

  logic [ID_W-1:0]     last_q;
  logic [MAX_ID_W-1:0] last_ext;
  logic [MAX_REQ-1:0]  valid_ext;
  tag_t                pick;
  tag_t                tag_d;
  tag_t                tag_q [MUL_LAT];
  tag_t                tail;
  logic                grant;
  logic [ID_W-1:0]     grant_id;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [WIDTH-1:0]    product;
  logic [15:0]         issue_cnt_q;
  logic                tag_busy;
  logic                tail_valid;
  logic [ID_W-1:0]     tail_id;
  logic [WIDTH-1:0]    tail_result;
  logic                unused_id_bits;

  // Arbitration: pick the next requester after last; reset masks the grant
  always_comb begin
    last_ext               = '0;
    last_ext[ID_W-1:0]     = last_q;
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
    pick                   = rr_pick(last_ext, valid_ext, NUM_REQ);
    grant                  = pick.valid & ~reset;
    grant_id               = pick.id[ID_W-1:0];
    req_ready              = '0;
    if (grant) begin
      req_ready[grant_id] = 1'b1;
    end
    op_a      = req_a[grant_id*WIDTH +: WIDTH];
    op_b      = req_b[grant_id*WIDTH +: WIDTH];
    tag_d     = '0;
    tag_d.valid = grant;
    tag_d.id    = pick.id;
  end

  // Pointer and accepted-operation counter advance only on a real transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= ID_W'(NUM_REQ - 1);
      issue_cnt_q <= '0;
    end else if (grant) begin
      last_q      <= grant_id;
      issue_cnt_q <= issue_cnt_q + 16'd1;
    end
  end

  // Tag shift register runs in lockstep with the multiplier stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  mul_pipe #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk (clk),
    .a_i (op_a),
    .b_i (op_b),
    .p_o (product)
  );

  // Any live tag means work is in flight; tail data is zeroed when no response is due
  always_comb begin
    tag_busy = 1'b0;
    for (int s = 0; s < MUL_LAT; s++) begin
      tag_busy = tag_busy | tag_q[s].valid;
    end
    tail        = tag_q[MUL_LAT-1];
    tail_valid  = tail.valid;
    tail_id     = tail.valid ? tail.id[ID_W-1:0] : '0;
    tail_result = tail.valid ? product : '0;
  end

  assign unused_id_bits = ^{pick.id, tail.id};
  assign issue_cnt      = issue_cnt_q;

`ifdef MUL_ARB_OUT_REG_EN
  logic             out_valid_q;
  logic [ID_W-1:0]  out_id_q;
  logic [WIDTH-1:0] out_result_q;

  // Extra response register stage adds one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_result_q <= '0;
    end else begin
      out_valid_q  <= tail_valid;
      out_id_q     <= tail_id;
      out_result_q <= tail_result;
    end
  end

  assign rsp_valid  = out_valid_q;
  assign rsp_id     = out_id_q;
  assign rsp_result = out_result_q;
  assign busy       = tag_busy | out_valid_q;
`else
  assign rsp_valid  = tail_valid;
  assign rsp_id     = tail_id;
  assign rsp_result = tail_result;
  assign busy       = tag_busy;
`endif

endmodule
